// File: rtl/alu_norm_pkg.sv
// Shared types and helpers for the normal-path lane divider.
package alu_norm_pkg;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Default lane operand width.
    localparam int DIV_DEFAULT_WIDTH = 32;

    // Step-counter width: enough bits to count DATA_WIDTH iterations.
    function automatic int divCntWidth(input int dataWidth);
        return $clog2(dataWidth + 1);
    endfunction

endpackage

// File: rtl/alu_norm_div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor magnitude, keep or restore the result.
module div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH:0]   remIn_i,
    input  logic                  dividendBit_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH:0]   remOut_o,
    output logic                  quotBit_o
);

    logic [DATA_WIDTH+1:0] shifted;
    logic [DATA_WIDTH:0]   diff;
    logic                  noBorrow;

    // Shift, trial subtract, and pick the difference only when it did not borrow.
    always_comb begin
        shifted   = {remIn_i, dividendBit_i};
        noBorrow  = (shifted >= {2'b00, divisor_i});
        diff      = shifted[DATA_WIDTH:0] - {1'b0, divisor_i};
        quotBit_o = noBorrow;
        remOut_o  = noBorrow ? diff : shifted[DATA_WIDTH:0];
    end

endmodule

// File: rtl/alu_norm_div.sv
// Iterative radix-2 restoring divider for one normal-path ALU lane.
// Result is {remainder, quotient}; fixed latency of DATA_WIDTH+2 cycles.
module alu_norm_div
    import alu_norm_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic [DATA_WIDTH-1:0]   a_i,
    input  logic [DATA_WIDTH-1:0]   b_i,
    input  logic                    tc_i,
    output logic                    ready_o,
    output logic                    valid_o,
    output logic [2*DATA_WIDTH-1:0] result_o
);

    localparam int              CNT_W     = divCntWidth(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_WIDTH - 1);

    div_state_e                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [DATA_WIDTH:0]       prem_q, prem_d;
    logic [DATA_WIDTH-1:0]     quot_q, quot_d;
    logic [DATA_WIDTH-1:0]     divMag_q, divMag_d;
    logic [DATA_WIDTH-1:0]     aRaw_q, aRaw_d;
    logic                      signA_q, signA_d;
    logic                      signB_q, signB_d;
    logic                      tc_q, tc_d;
    logic                      divZero_q, divZero_d;
    logic [2*DATA_WIDTH-1:0]   result_q, result_d;

    logic [DATA_WIDTH:0]       stepRem;
    logic                      stepQBit;
    logic [DATA_WIDTH-1:0]     quotFix;
    logic [DATA_WIDTH-1:0]     remFix;
    logic [2*DATA_WIDTH-1:0]   fixResult;

    // quot_q holds the remaining dividend bits at the top while quotient bits enter at the bottom.
    div_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .remIn_i       (prem_q),
        .dividendBit_i (quot_q[DATA_WIDTH-1]),
        .divisor_i     (divMag_q),
        .remOut_o      (stepRem),
        .quotBit_o     (stepQBit)
    );

    // Sign correction of the magnitude results, with the divide-by-zero override.
    always_comb begin
        quotFix = (tc_q && (signA_q ^ signB_q)) ? -quot_q : quot_q;
        remFix  = (tc_q && signA_q) ? -prem_q[DATA_WIDTH-1:0] : prem_q[DATA_WIDTH-1:0];
        if (divZero_q) begin
            fixResult = {aRaw_q, {DATA_WIDTH{1'b1}}};
        end else begin
            fixResult = {remFix, quotFix};
        end
    end

    // Next-state logic: issue in IDLE/DONE, iterate in CALC, write the result in FIX.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prem_d    = prem_q;
        quot_d    = quot_q;
        divMag_d  = divMag_q;
        aRaw_d    = aRaw_q;
        signA_d   = signA_q;
        signB_d   = signB_q;
        tc_d      = tc_q;
        divZero_d = divZero_q;
        result_d  = result_q;
        case (state_q)
            IDLE, DONE: begin
                if (en_i) begin
                    signA_d   = a_i[DATA_WIDTH-1];
                    signB_d   = b_i[DATA_WIDTH-1];
                    quot_d    = (tc_i && a_i[DATA_WIDTH-1]) ? -a_i : a_i;
                    divMag_d  = (tc_i && b_i[DATA_WIDTH-1]) ? -b_i : b_i;
                    tc_d      = tc_i;
                    divZero_d = (b_i == '0);
                    aRaw_d    = a_i;
                    cnt_d     = '0;
                    prem_d    = '0;
                    state_d   = CALC;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                prem_d = stepRem;
                quot_d = {quot_q[DATA_WIDTH-2:0], stepQBit};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = fixResult;
                state_d  = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prem_q    <= '0;
            quot_q    <= '0;
            divMag_q  <= '0;
            aRaw_q    <= '0;
            signA_q   <= 1'b0;
            signB_q   <= 1'b0;
            tc_q      <= 1'b0;
            divZero_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prem_q    <= prem_d;
            quot_q    <= quot_d;
            divMag_q  <= divMag_d;
            aRaw_q    <= aRaw_d;
            signA_q   <= signA_d;
            signB_q   <= signB_d;
            tc_q      <= tc_d;
            divZero_q <= divZero_d;
            result_q  <= result_d;
        end
    end

    assign ready_o  = (state_q == IDLE) || (state_q == DONE);
    assign valid_o  = (state_q == DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_alu_norm_div.sv
// Testbench for alu_norm_div: directed literal cases plus a randomized run,
// with a cycle-level reference of the handshake and result checked every cycle.
module tb_alu_norm_div;

    localparam int W = 32;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b1;
    logic           en_i  = 1'b0;
    logic           tc_i  = 1'b0;
    logic [W-1:0]   a_i   = '0;
    logic [W-1:0]   b_i   = '0;
    logic           ready_o;
    logic           valid_o;
    logic [2*W-1:0] result_o;

    int             checks = 0;
    int             errors = 0;
    int             edges  = 0;
    int             pendDue = -1;
    logic [2*W-1:0] pendExp = '0;
    logic [2*W-1:0] lastResult = '0;

    alu_norm_div #(
        .DATA_WIDTH (W)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (en_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .tc_i     (tc_i),
        .ready_o  (ready_o),
        .valid_o  (valid_o),
        .result_o (result_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference result from plain integer arithmetic: {remainder, quotient}.
    function automatic logic [2*W-1:0] refDiv(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic tc);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == '0) return {a, {W{1'b1}}};
        if (!tc) return {a % b, a / b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[W-1:0], q[W-1:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference timeline: an issue at edge N completes with valid visible until edge N+W+2.
    always @(posedge rst_i) begin
        pendDue    = -1;
        lastResult = '0;
    end

    always @(posedge clk_i) begin
        edges++;
        if (rst_i) begin
            pendDue    = -1;
            lastResult = '0;
        end else begin
            if (pendDue >= 0 && edges == pendDue - 1) lastResult = pendExp;
            if (pendDue < 0 || edges >= pendDue) begin
                pendDue = -1;
                if (en_i) begin
                    pendDue = edges + W + 2;
                    pendExp = refDiv(a_i, b_i, tc_i);
                end
            end
        end
    end

    // Every cycle: handshake outputs and held result must match the reference timeline.
    always @(negedge clk_i) begin
        logic expValid;
        logic expReady;
        expValid = (pendDue >= 0) && (edges + 1 == pendDue);
        expReady = (pendDue < 0) || expValid;
        checkOutput("cycle valid_o", 64'(valid_o), 64'(expValid));
        checkOutput("cycle ready_o", 64'(ready_o), 64'(expReady));
        checkOutput("cycle result_o", result_o, lastResult);
    end

    // Issue one operation; called just after a clock edge while the DUT is ready.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic tc);
        a_i  = a;
        b_i  = b;
        tc_i = tc;
        en_i = 1'b1;
        @(posedge clk_i);
        #1;
        en_i = 1'b0;
        a_i  = $urandom;
        b_i  = $urandom;
        tc_i = 1'($urandom_range(0, 1));
    endtask

    // Wait (bounded) for valid_o; check edges since the call and the literal result.
    task automatic waitResult(input string name, input logic [W-1:0] expQ,
                              input logic [W-1:0] expR, input int expK);
        int k;
        for (k = 1; k <= W + 10; k++) begin
            @(posedge clk_i);
            #1;
            if (valid_o) break;
        end
        checkOutput({name, " latency"}, 64'(k), 64'(expK));
        checkOutput({name, " result"}, result_o, {expR, expQ});
    endtask

    function automatic logic [W-1:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return W'($urandom_range(1, 15));
            2:       return '1;
            3:       return W'(32'h8000_0000);
            4:       return W'($urandom) >> $urandom_range(0, W - 1);
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #1;
        checkOutput("reset valid_o", 64'(valid_o), 64'(0));
        checkOutput("reset ready_o", 64'(ready_o), 64'(1));
        checkOutput("reset result_o", result_o, 64'(0));
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        checkOutput("model 100/7", refDiv(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
        checkOutput("model -7/2", refDiv(32'hFFFF_FFF9, 32'd2, 1'b1), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        checkOutput("model ovf", refDiv(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), {32'd0, 32'h8000_0000});

        applyStimulus(32'd100, 32'd7, 1'b0);
        waitResult("u100/7", 32'd14, 32'd2, W + 1);
        @(posedge clk_i);
        #1;
        checkOutput("valid pulse width", 64'(valid_o), 64'(0));

        applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1);
        waitResult("s-7/2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, W + 1);
        applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1);
        waitResult("s7/-2", 32'hFFFF_FFFD, 32'd1, W + 1);
        applyStimulus(32'd5, 32'd0, 1'b0);
        waitResult("u5/0", 32'hFFFF_FFFF, 32'd5, W + 1);
        applyStimulus(32'hFFFF_FFF9, 32'd0, 1'b1);
        waitResult("s-7/0", 32'hFFFF_FFFF, 32'hFFFF_FFF9, W + 1);
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        waitResult("s ovf", 32'h8000_0000, 32'd0, W + 1);
        applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0);
        waitResult("uMax/1", 32'hFFFF_FFFF, 32'd0, W + 1);

        a_i  = 32'd1000;
        b_i  = 32'd10;
        tc_i = 1'b0;
        en_i = 1'b1;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 10; i++) begin
            a_i  = $urandom;
            b_i  = $urandom;
            tc_i = 1'($urandom_range(0, 1));
            @(posedge clk_i);
            #1;
        end
        en_i = 1'b0;
        waitResult("hold en", 32'd100, 32'd0, W + 1 - 10);

        applyStimulus(32'd100, 32'd7, 1'b0);
        waitResult("b2b first", 32'd14, 32'd2, W + 1);
        applyStimulus(32'd20, 32'd3, 1'b0);
        waitResult("b2b second", 32'd6, 32'd2, W + 1);

        applyStimulus(32'd12345, 32'd6, 1'b0);
        repeat (9) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        checkOutput("midreset valid_o", 64'(valid_o), 64'(0));
        checkOutput("midreset ready_o", 64'(ready_o), 64'(1));
        checkOutput("midreset result_o", result_o, 64'(0));
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        applyStimulus(32'd9, 32'd4, 1'b0);
        waitResult("after reset 9/4", 32'd2, 32'd1, W + 1);

        for (int i = 0; i < 6000; i++) begin
            en_i = ($urandom_range(0, 3) != 0);
            a_i  = pickOperand();
            b_i  = pickOperand();
            tc_i = 1'($urandom_range(0, 1));
            @(posedge clk_i);
            #1;
        end
        en_i = 1'b0;
        repeat (W + 5) @(posedge clk_i);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
